output_packer: RTL

Write-side counterpart of `feature_loader`. It accepts scaled output vectors from `output_scaler_set`, packs several of them into one internal-interface word of the activation buffer, and issues writes to the buffer's internal write port (`wr_data_2_i/wr_en_2_i/wr_addr_2_i`) at incrementing byte addresses. `qracc_controller` arms it with a base address and a vector count, and it reports completion back to the controller.

---
 rtl/output_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/output_packer.sv
// Packs scaled output vectors into wide activation-buffer words and issues
// one write per full word (or per final partial word) at incrementing byte addresses.
module output_packer #(
    parameter int numElements  = 32,
    parameter int elementWidth = 4,
    parameter int wordWidth    = 512,
    parameter int addrWidth    = 32,
    parameter int countWidth   = 16
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start_i,
    input  logic                                clear_i,
    input  logic [addrWidth-1:0]                base_addr_i,
    input  logic [countWidth-1:0]               num_vectors_i,
    input  logic [numElements*elementWidth-1:0] data_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    output logic                                wr_en_o,
    output logic [addrWidth-1:0]                wr_addr_o,
    output logic [wordWidth-1:0]                wr_data_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int vecWidth  = numElements * elementWidth;
    localparam int lanes     = wordWidth / vecWidth;
    localparam int addrStep  = wordWidth / 8;
    localparam int laneWidth = (lanes > 1) ? $clog2(lanes) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [addrWidth-1:0]   addr_reg;
    logic [countWidth-1:0]  remaining;
    logic [laneWidth-1:0]   lane;
    logic [wordWidth-1:0]   shadow;
    logic [wordWidth-1:0]   merged;
    logic                   accept;
    logic                   last_vec;
    logic                   lane_full;
    logic                   emit;

    assign accept    = (state == PACK) && valid_i && !clear_i;
    assign last_vec  = (remaining == countWidth'(1));
    assign lane_full = (lane == laneWidth'(lanes - 1));
    assign emit      = accept && (last_vec || lane_full);

    assign ready_o = (state == PACK);
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);

    // Word as it would look with the incoming vector dropped into the current lane;
    // lanes above the current one are forced to zero so a partial flush is clean.
    always_comb begin
        merged = shadow;
        for (int i = 0; i < lanes; i++) begin
            if (lane == laneWidth'(i)) begin
                merged[i*vecWidth +: vecWidth] = data_i;
            end else if (laneWidth'(i) > lane) begin
                merged[i*vecWidth +: vecWidth] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (num_vectors_i == '0) ? DONE : PACK;
                end
            end
            PACK: begin
                if (accept && last_vec) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_reg  <= '0;
            remaining <= '0;
            lane      <= '0;
            shadow    <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= 1'b0;
            if (clear_i) begin
                remaining <= '0;
                lane      <= '0;
                shadow    <= '0;
            end else if ((state == IDLE) && start_i) begin
                addr_reg  <= base_addr_i;
                remaining <= num_vectors_i;
                lane      <= '0;
                shadow    <= '0;
            end else if (accept) begin
                remaining <= remaining - countWidth'(1);
                if (emit) begin
                    wr_en_o   <= 1'b1;
                    wr_data_o <= merged;
                    wr_addr_o <= addr_reg;
                    addr_reg  <= addr_reg + addrWidth'(addrStep);
                    shadow    <= '0;
                    lane      <= '0;
                end else begin
                    shadow <= merged;
                    lane   <= lane + laneWidth'(1);
                end
            end
        end
    end

endmodule
